// File: rtl/ibex_data_bus_pkg.sv
// Shared types and counter widths for the data-bus responder.
package ibex_data_bus_pkg;

    localparam int unsigned STALL_W = 3;
    localparam int unsigned OUTST_W = 3;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } bus_resp_t;

endpackage

// File: rtl/ibex_data_bus_resp_pipe.sv
// Fixed-latency response pipeline: valid bit plus payload per stage.
module ibex_data_bus_resp_pipe
    import ibex_data_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      req_valid,
    input  bus_resp_t req_resp,
    output logic      rsp_valid,
    output bus_resp_t rsp
);

    logic [DEPTH-1:0] valid_q;
    bus_resp_t        resp_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                resp_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= req_valid;
            resp_q[0]  <= req_resp;
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_q[i] <= valid_q[i-1];
                resp_q[i]  <= resp_q[i-1];
            end
        end
    end

    assign rsp_valid = valid_q[DEPTH-1];
    assign rsp       = resp_q[DEPTH-1];

endmodule

// File: rtl/ibex_data_bus_responder.sv
// Memory-side responder for the core data bus: stalled grant, byte-enabled
// word array, and in-order fixed-latency responses.
module ibex_data_bus_responder
    import ibex_data_bus_pkg::*;
#(
    parameter int unsigned AW              = 10,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned GNT_STALL       = 0,
    parameter int unsigned RVALID_LAT      = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic        data_err_o,
    output logic [31:0] data_rdata_o
);

    localparam int unsigned WORDS = 2 ** AW;
    localparam logic [32:0] SPAN  = 33'(1) << (AW + 2);

    logic [31:0]        mem [WORDS];
    logic [STALL_W-1:0] stall_q;
    logic [OUTST_W-1:0] outst_q;
    logic [32:0]        offset;
    logic [AW-1:0]      idx;
    logic               in_range;
    logic               stall_done;
    logic               has_room;
    logic               gnt;
    logic               rsp_valid;
    bus_resp_t          resp_c;
    bus_resp_t          pipe_in;
    bus_resp_t          rsp;

    // Range check with a borrow bit so addresses below the base fail too.
    assign offset   = {1'b0, data_addr_i} - {1'b0, BASE_ADDR};
    assign in_range = ~offset[32] & (offset < SPAN);
    assign idx      = data_addr_i[AW+1:2];

    assign stall_done = (stall_q == STALL_W'(GNT_STALL));
    assign has_room   = (outst_q < OUTST_W'(MAX_OUTSTANDING)) | rsp_valid;
    assign gnt        = data_req_i & stall_done & has_room;
    assign data_gnt_o = gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (!data_req_i || gnt) begin
            stall_q <= '0;
        end else if (!stall_done) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outst_q <= '0;
        end else if (gnt && !rsp_valid) begin
            outst_q <= outst_q + OUTST_W'(1);
        end else if (!gnt && rsp_valid) begin
            outst_q <= outst_q - OUTST_W'(1);
        end
    end

    // Array is deliberately not reset; granted writes survive a reset.
    always_ff @(posedge clk_i) begin
        if (gnt && in_range && data_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read data is sampled from the pre-edge array contents (read-first).
    always_comb begin
        resp_c       = '0;
        resp_c.err   = ~in_range;
        if (in_range && !data_we_i) begin
            resp_c.rdata = mem[idx];
        end
        pipe_in = gnt ? resp_c : '0;
    end

    ibex_data_bus_resp_pipe #(
        .DEPTH (RVALID_LAT)
    ) u_resp_pipe (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_valid (gnt),
        .req_resp  (pipe_in),
        .rsp_valid (rsp_valid),
        .rsp       (rsp)
    );

    assign data_rvalid_o = rsp_valid;
    assign data_err_o    = rsp.err;
    assign data_rdata_o  = rsp.rdata;

endmodule

// File: tb/tb_ibex_data_bus_responder.sv
// Self-checking bench: u0 (no stall, latency 2) runs a vector table through a
// response scoreboard; u1 (stall 3, latency 3) covers stall and reset corners.
module tb_ibex_data_bus_responder;

    localparam int unsigned LAT0 = 2;
    localparam int unsigned LAT1 = 3;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          gcyc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];

    logic        rst0_n, req0, gnt0, we0, rvalid0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [3:0]  be0;
    logic        rst1_n, req1, gnt1, we1, rvalid1, err1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [3:0]  be1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ibex_data_bus_responder #(
        .AW(10), .BASE_ADDR(32'h0), .GNT_STALL(0), .RVALID_LAT(LAT0), .MAX_OUTSTANDING(2)
    ) u0 (
        .clk_i(clk), .rst_ni(rst0_n), .data_req_i(req0), .data_gnt_o(gnt0),
        .data_addr_i(addr0), .data_we_i(we0), .data_be_i(be0), .data_wdata_i(wdata0),
        .data_rvalid_o(rvalid0), .data_err_o(err0), .data_rdata_o(rdata0)
    );

    ibex_data_bus_responder #(
        .AW(10), .BASE_ADDR(32'h0), .GNT_STALL(3), .RVALID_LAT(LAT1), .MAX_OUTSTANDING(2)
    ) u1 (
        .clk_i(clk), .rst_ni(rst1_n), .data_req_i(req1), .data_gnt_o(gnt1),
        .data_addr_i(addr1), .data_we_i(we1), .data_be_i(be1), .data_wdata_i(wdata1),
        .data_rvalid_o(rvalid1), .data_err_o(err1), .data_rdata_o(rdata1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: every u0 response is matched against the oldest grant.
    always @(negedge clk) begin
        if (rst0_n && rvalid0) begin
            if (sb_q.size() == 0) begin
                chk("spurious_rvalid", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rdata", rdata0, e.rdata);
                chk("err", 32'(err0), 32'(e.err));
                chk("latency", 32'(cyc - e.gcyc), 32'(LAT0));
            end
        end
    end

    task automatic issue0(input vec_t v, output int waitc, output int gc);
        exp_t e;
        req0 = 1'b1; we0 = v.we; addr0 = v.addr; be0 = v.be; wdata0 = v.wdata;
        waitc = 0;
        gc = -1;
        forever begin
            @(negedge clk);
            if (gnt0) break;
            waitc++;
            if (waitc > 20) begin
                chk("gnt0_timeout", 32'(waitc), 32'd0);
                req0 = 1'b0;
                return;
            end
        end
        gc = cyc;
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.gcyc = cyc;
        sb_q.push_back(e);
        @(posedge clk); #1;
        req0 = 1'b0;
    endtask

    task automatic drain0();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic issue1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int waitc, output int gc);
        req1 = 1'b1; we1 = we; addr1 = addr; be1 = 4'hF; wdata1 = wdata;
        waitc = 0;
        gc = -1;
        forever begin
            @(negedge clk);
            if (gnt1) break;
            waitc++;
            if (waitc > 20) begin
                chk("gnt1_timeout", 32'(waitc), 32'd0);
                req1 = 1'b0;
                return;
            end
        end
        gc = cyc;
        @(posedge clk); #1;
        req1 = 1'b0;
    endtask

    task automatic watch1(input int n, output int cnt, output int fc, output logic [31:0] rd,
                          output logic er);
        cnt = 0; fc = -1; rd = '0; er = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rvalid1) begin
                if (cnt == 0) begin
                    fc = cyc; rd = rdata1; er = err1;
                end
                cnt++;
            end
        end
        @(posedge clk); #1;
    endtask

    vec_t vecs[13];

    initial begin
        int w, g, g1, g2, g3, cnt, fc;
        logic [31:0] rd;
        logic er;
        vec_t v;

        //        we    addr          be     wdata          exp_rdata      err
        vecs[0]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'h1122_3344, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0010, 4'h5, 32'hAABB_CCDD, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'h11BB_33DD, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0010, 4'h0, 32'h1234_5678, 32'h0,         1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_1000, 4'hF, 32'h5566_7788, 32'h0,         1'b1};
        vecs[8]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'h00C0_FFEE, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_1004, 4'hF, 32'h0,         32'h0,         1'b1};
        vecs[10] = '{1'b1, 32'h0000_0FFC, 4'hC, 32'hFFFF_0000, 32'h0,         1'b0};
        vecs[11] = '{1'b0, 32'h0000_0FFC, 4'hF, 32'h0,         32'hFFFF_5678, 1'b0};
        vecs[12] = '{1'b0, 32'h0000_0013, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0};

        rst0_n = 1'b0; req0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = '0; wdata0 = '0;
        rst1_n = 1'b0; req1 = 1'b0; we1 = 1'b0; addr1 = '0; be1 = '0; wdata1 = '0;

        u0.mem[0]    = 32'h00C0_FFEE;
        u0.mem[4]    = 32'h1122_3344;
        u0.mem[8]    = 32'h0A0A_0A0A;
        u0.mem[9]    = 32'h0B0B_0B0B;
        u0.mem[10]   = 32'h0C0C_0C0C;
        u0.mem[1023] = 32'h1234_5678;
        u1.mem[0]    = 32'h5A5A_5A5A;
        u1.mem[1]    = 32'h6B6B_6B6B;
        u1.mem[3]    = 32'h3C3C_3C3C;

        repeat (2) @(negedge clk);
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_err0", 32'(err0), 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        @(posedge clk); #1;
        rst0_n = 1'b1; rst1_n = 1'b1;
        @(posedge clk); #1;

        // Vector table, issued back to back
        for (int i = 0; i < 13; i++) begin
            issue0(vecs[i], w, g);
            if (i == 0) chk("gnt_same_cycle", 32'(w), 32'd0);
        end
        drain0();

        // Split access: two consecutive grants, third held until first rvalid
        v = '{1'b0, 32'h20, 4'hF, 32'h0, 32'h0A0A_0A0A, 1'b0};
        issue0(v, w, g1);
        chk("split_first_wait", 32'(w), 32'd0);
        v = '{1'b0, 32'h24, 4'hF, 32'h0, 32'h0B0B_0B0B, 1'b0};
        issue0(v, w, g2);
        v = '{1'b0, 32'h28, 4'hF, 32'h0, 32'h0C0C_0C0C, 1'b0};
        issue0(v, w, g3);
        chk("split_gnt2_gap", 32'(g2 - g1), 32'd1);
        chk("split_gnt3_gap", 32'(g3 - g1), 32'(LAT0));
        drain0();

        // Stall with req held: grant in the 4th cycle
        issue1(1'b0, 32'h0, 32'h0, w, g);
        chk("stall_held", 32'(w), 32'd3);
        watch1(6, cnt, fc, rd, er);
        chk("stall_rsp_cnt", 32'(cnt), 32'd1);
        chk("stall_rsp_lat", 32'(fc - g), 32'(LAT1));
        chk("stall_rsp_rdata", rd, 32'h5A5A_5A5A);

        // Abandoned request: counter restarts on reassertion
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4; be1 = 4'hF;
        @(negedge clk); chk("abandon_gnt_c1", 32'(gnt1), 32'd0);
        @(negedge clk); chk("abandon_gnt_c2", 32'(gnt1), 32'd0);
        @(posedge clk); #1; req1 = 1'b0;
        @(posedge clk); #1;
        issue1(1'b0, 32'h4, 32'h0, w, g);
        chk("stall_restart", 32'(w), 32'd3);
        watch1(6, cnt, fc, rd, er);
        chk("restart_rsp_cnt", 32'(cnt), 32'd1);
        chk("restart_rsp_rdata", rd, 32'h6B6B_6B6B);

        // Reset mid-flight: granted write survives, in-flight read vanishes
        issue1(1'b1, 32'h8, 32'h7777_7777, w, g);
        watch1(6, cnt, fc, rd, er);
        chk("write_rsp_rdata", rd, 32'h0);
        issue1(1'b0, 32'hC, 32'h0, w, g);
        rst1_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("inrst_rvalid1", 32'(rvalid1), 32'd0);
            chk("inrst_gnt1", 32'(gnt1), 32'd0);
            chk("inrst_err1", 32'(err1), 32'd0);
            chk("inrst_rdata1", rdata1, 32'd0);
        end
        @(posedge clk); #1;
        rst1_n = 1'b1;
        watch1(8, cnt, fc, rd, er);
        chk("post_rst_no_rvalid", 32'(cnt), 32'd0);
        issue1(1'b0, 32'h8, 32'h0, w, g);
        watch1(6, cnt, fc, rd, er);
        chk("post_rst_rsp_cnt", 32'(cnt), 32'd1);
        chk("write_survives_rst", rd, 32'h7777_7777);
        chk("post_rst_err", 32'(er), 32'd0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
